// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the uart transmit path
package uart_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} arb_state_t;
  localparam int UART_BAUD_CYCLES = 33;
  localparam int MAX_BURST_DEFAULT = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first valid index at or after ptr
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick,
  output logic                 any
);
  always_comb begin
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % N]) begin
        pick = '0;
        pick[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end
  assign any = |valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one uart_tx among NUM_REQ byte streams
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  input  logic [NUM_REQ-1:0][7:0] req_byte_in,
  input  logic [NUM_REQ-1:0]      req_last_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  output logic                    tx_valid_out,
  output logic [7:0]              tx_byte_out,
  input  logic                    tx_ready_in,
  output logic [NUM_REQ-1:0]      grant_out,
  output logic                    busy_out
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_t state, state_nx;
  logic [NUM_REQ-1:0] grant, pick;
  logic [IW-1:0] ptr, gidx, pick_idx;
  logic [CW-1:0] cnt;
  logic any, last_q, accept, rotate;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid(req_valid_in),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (pick[i]) pick_idx = IW'(i);
  end
  assign accept = state == ISSUE && (req_valid_in & grant) != '0 && tx_ready_in;
  assign rotate = state == WAIT_DONE && tx_ready_in && (last_q || cnt == CW'(MAX_BURST));
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE      ? (any ? ISSUE : IDLE) :
               state == ISSUE     ? (accept ? WAIT_BUSY : ISSUE) :
               state == WAIT_BUSY ? (tx_ready_in ? WAIT_BUSY : WAIT_DONE) :
                                    (tx_ready_in ? (rotate ? IDLE : ISSUE) : WAIT_DONE);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      grant        <= '0;
      gidx         <= '0;
      ptr          <= '0;
      cnt          <= '0;
      last_q       <= 1'b0;
      tx_valid_out <= 1'b0;
      tx_byte_out  <= 8'h00;
    end else begin
      state        <= state_nx;
      tx_valid_out <= accept;
      if (state == IDLE && any) begin
        grant <= pick;
        gidx  <= pick_idx;
        cnt   <= '0;
      end
      if (accept) begin
        tx_byte_out <= req_byte_in[gidx];
        last_q      <= req_last_in[gidx];
        cnt         <= cnt + CW'(1);
      end
      if (rotate) begin
        grant <= '0;
        ptr   <= gidx == IW'(NUM_REQ - 1) ? '0 : gidx + IW'(1);
      end
    end
  end
  assign req_ready_out = accept ? grant : '0;
  assign grant_out     = grant;
  assign busy_out      = state != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with queued requesters and a behavioural uart_tx handshake
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int FRAME = 20;
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic [N-1:0] req_valid_in = '0;
  logic [N-1:0] req_last_in = '0;
  logic [N-1:0][7:0] req_byte_in = '0;
  logic [N-1:0] req_ready_out, grant_out;
  logic tx_valid_out, busy_out;
  logic [7:0] tx_byte_out;
  logic tx_ready_in = 1'b1;
  int busy_cnt = 0;
  int checks = 0;
  int failures = 0;
  logic [8:0] q0[$], q1[$], q2[$], q3[$];
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  logic [9:0] h;
  logic [N-1:0] en = '1;
  logic [N-1:0] rdy_s = '0;
  logic prev_v = 1'b0;
  logic [N-1:0] g_or, g_and, r_or;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(16)) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .req_valid_in (req_valid_in),
    .req_byte_in  (req_byte_in),
    .req_last_in  (req_last_in),
    .req_ready_out(req_ready_out),
    .tx_valid_out (tx_valid_out),
    .tx_byte_out  (tx_byte_out),
    .tx_ready_in  (tx_ready_in),
    .grant_out    (grant_out),
    .busy_out     (busy_out)
  );
  always @(posedge clk) begin
    if (tx_ready_in && tx_valid_out) begin
      tx_ready_in <= 1'b0;
      busy_cnt    <= FRAME;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt    <= 0;
      tx_ready_in <= 1'b1;
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  function automatic logic [9:0] head(int i);
    case (i)
      0:       return q0.size() > 0 ? {1'b1, q0[0]} : 10'h0;
      1:       return q1.size() > 0 ? {1'b1, q1[0]} : 10'h0;
      2:       return q2.size() > 0 ? {1'b1, q2[0]} : 10'h0;
      default: return q3.size() > 0 ? {1'b1, q3[0]} : 10'h0;
    endcase
  endfunction
  task automatic pop(int i);
    case (i)
      0:       if (q0.size() > 0) void'(q0.pop_front());
      1:       if (q1.size() > 0) void'(q1.pop_front());
      2:       if (q2.size() > 0) void'(q2.pop_front());
      default: if (q3.size() > 0) void'(q3.pop_front());
    endcase
  endtask
  task automatic push(int i, logic [7:0] b, logic l);
    case (i)
      0:       q0.push_back({l, b});
      1:       q1.push_back({l, b});
      2:       q2.push_back({l, b});
      default: q3.push_back({l, b});
    endcase
  endtask
  task automatic expect_tx(logic [3:0] g, logic [7:0] b);
    exp_q.push_back({g, b});
  endtask
  always @(negedge clk) rdy_s = req_ready_out;
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rdy_s[i]) pop(i);
      h = head(i);
      req_valid_in[i] = h[9] && en[i];
      req_last_in[i]  = h[8];
      req_byte_in[i]  = h[7:0];
    end
  end
  always @(negedge clk) begin
    if (!rst_in && tx_valid_out) begin
      chk("tx_pulse_width", 32'(prev_v), 32'(0));
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stray_tx actual byte=%02h grant=%b required no pulse", tx_byte_out, grant_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tx_byte", 32'(tx_byte_out), 32'(mon_e[7:0]));
        chk("tx_grant", 32'(grant_out), 32'(mon_e[11:8]));
      end
    end
    prev_v = tx_valid_out;
  end
  task automatic wait_exp(string name, int k);
    int n = 0;
    while (exp_q.size() > k && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size() <= k), 32'(1));
  endtask
  task automatic drain(string name);
    int n = 0;
    while ((exp_q.size() > 0 || busy_out) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'(0));
    chk({name, "_idle"}, 32'(busy_out), 32'(0));
    @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid_out), 32'(0));
    chk("rst_tx_byte", 32'(tx_byte_out), 32'(0));
    chk("rst_ready", 32'(req_ready_out), 32'(0));
    chk("rst_grant", 32'(grant_out), 32'(0));
    chk("rst_busy", 32'(busy_out), 32'(0));
    rst_in = 1'b0;
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    expect_tx(4'b0001, 8'h41); expect_tx(4'b0001, 8'h42); expect_tx(4'b0001, 8'h43);
    drain("s1");
    push(0, 8'h50, 1'b1); push(1, 8'h51, 1'b1);
    expect_tx(4'b0010, 8'h51); expect_tx(4'b0001, 8'h50);
    drain("s1_ptr");
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      push(i, 8'hA0 + 8'(i), 1'b1);
      expect_tx(4'(1 << i), 8'hA0 + 8'(i));
    end
    drain("s2");
    for (int k = 0; k < 6; k++) push(0, 8'hB0 + 8'(k), 1'b1);
    expect_tx(4'b0001, 8'hB0); expect_tx(4'b0001, 8'hB1);
    wait_exp("s3_wait", 0);
    push(2, 8'hC2, 1'b1);
    expect_tx(4'b0100, 8'hC2);
    for (int k = 2; k < 6; k++) expect_tx(4'b0001, 8'hB0 + 8'(k));
    drain("s3");
    for (int k = 0; k < 20; k++) push(1, 8'(k), k == 19);
    push(3, 8'h77, 1'b1);
    for (int k = 0; k < 16; k++) expect_tx(4'b0010, 8'(k));
    expect_tx(4'b1000, 8'h77);
    for (int k = 16; k < 20; k++) expect_tx(4'b0010, 8'(k));
    drain("s4");
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1); push(0, 8'h30, 1'b1);
    expect_tx(4'b0100, 8'h20); expect_tx(4'b0100, 8'h21);
    expect_tx(4'b0100, 8'h22); expect_tx(4'b0001, 8'h30);
    wait_exp("s5_wait", 2);
    en[2] = 1'b0;
    g_or = '0; g_and = '1; r_or = '0;
    repeat (500) begin
      @(negedge clk);
      g_or  = g_or | grant_out;
      g_and = g_and & grant_out;
      r_or  = r_or | req_ready_out;
    end
    chk("s5_grant_or", 32'(g_or), 32'(4'b0100));
    chk("s5_grant_and", 32'(g_and), 32'(4'b0100));
    chk("s5_ready", 32'(r_or), 32'(0));
    chk("s5_held", 32'(exp_q.size()), 32'(2));
    en[2] = 1'b1;
    drain("s5");
    push(1, 8'h66, 1'b1);
    expect_tx(4'b0010, 8'h66);
    wait_exp("s6_wait", 0);
    n = 0;
    while (tx_ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s6_uart_busy", 32'(tx_ready_in), 32'(0));
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    chk("s6_rst_outputs", 32'({tx_valid_out, tx_byte_out, req_ready_out, grant_out}), 32'(0));
    chk("s6_rst_busy", 32'(busy_out), 32'(0));
    rst_in = 1'b0;
    push(3, 8'h99, 1'b1);
    expect_tx(4'b1000, 8'h99);
    n = 0;
    while (grant_out == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s6_grant", 32'(grant_out), 32'(4'b1000));
    drain("s6");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` serializer among `NUM_REQ` byte-stream requesters. It sits directly in front of `uart_tx`. It drives that block's `valid_in`/`byte_in` and watches its `ready_out`. Each grant covers a whole packet, delimited by a `last` flag, so bytes from different requesters never interleave on the wire. A burst cap forces rotation so no single requester can starve the others.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MAX_BURST`, default 16: maximum bytes sent per grant before grant is forced to rotate.
- `clk_in` input 1: system clock, 100 MHz.
- `rst_in` input 1: reset, synchronous, active-high.
- `req_valid_in` input `NUM_REQ`: requester i has a byte.
- `req_byte_in` input `NUM_REQ`x8: byte from each requester.
- `req_last_in` input `NUM_REQ`: byte is the final byte of its packet.
- `req_ready_out` output `NUM_REQ`: one-cycle accept strobe to the granted requester.
- `tx_valid_out` output 1: connects to `uart_tx.valid_in`.
- `tx_byte_out` output 8: connects to `uart_tx.byte_in`.
- `tx_ready_in` input 1: connects to `uart_tx.ready_out`.
- `grant_out` output `NUM_REQ`: one-hot current grant, or 0 when idle.
- `busy_out` output 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: no grant.
  - ISSUE: a requester is granted and the arbiter waits to accept its next byte.
  - WAIT_BUSY: waits for `tx_ready_in`=0.
  - WAIT_DONE: waits for `tx_ready_in`=1.
- **IDLE.** If any `req_valid_in` is high, pick the first valid index at or after pointer `ptr`, wrapping modulo `NUM_REQ`. Register the grant, clear burst count `cnt`, go to ISSUE. If nothing is valid, stay in IDLE.
- **ISSUE.** A byte is accepted when `req_valid_in[g]` and `tx_ready_in` are both high.
  - On accept: `req_ready_out[g]` is high combinationally in that cycle. The byte goes into the `tx_byte_out` register, `last` is latched, `cnt` increments, and the state goes to WAIT_BUSY.
  - If `req_valid_in[g]` is low, hold the grant indefinitely (packet lock). No other requester is served.
- **WAIT_BUSY.** Stay until `tx_ready_in`=0, then go to WAIT_DONE.
- **WAIT_DONE.** Stay until `tx_ready_in`=1. Then:
  - If latched `last` or `cnt`==`MAX_BURST`: set `ptr`=(g+1) mod `NUM_REQ`, clear the grant, go to IDLE.
  - Otherwise go to ISSUE.
- `req_ready_out[i]` is always 0 for i≠g, and 0 outside ISSUE.
- `cnt` is wide enough to hold `MAX_BURST` (clog2(`MAX_BURST`+1) bits). It never wraps, because it is cleared on each new grant.
- When `cnt` hits `MAX_BURST` on a non-last byte, the rest of that packet continues on the requester's next grant. No byte is dropped or duplicated.
- Requesters that go valid while a grant is active wait for the next IDLE arbitration.

## Timing
- **Reset:** one cycle of `rst_in` gives state IDLE and `ptr`=0, with all outputs low: `tx_valid_out`=0, `tx_byte_out`=8'h00, `req_ready_out`=0, `grant_out`=0, `busy_out`=0.
- **Reset mid-operation** (any state) takes effect on the next edge. A `uart_tx` frame already in flight is not aborted by this block.
- **Arbitration:** a request seen in IDLE at edge t gives `grant_out` valid after t. The earliest accept is the cycle after t.
- **Accept to send:** if the accept happens in cycle t, then `tx_valid_out`=1 in cycle t+1 only (exactly one cycle). `tx_byte_out` is valid from t+1 and held until the next accept.
- **Byte spacing:** the next accept of the same grant comes no earlier than one cycle after `tx_ready_in` rises. At 33 cycles/bit this gives about 331 cycles per byte.
- **Simultaneous requests:** resolved purely by the `ptr` rotation. Index order breaks ties starting from `ptr`.

## Structure
- Shared package `uart_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE};
  - `UART_BAUD_CYCLES`=33;
  - default `MAX_BURST`.
- Sub-module `rr_pick`: purely combinational. Takes the valid vector and `ptr`, returns a one-hot choice and an any-valid flag. It is reused by later shared-resource blocks.
- The top contains the FSM, grant/`ptr`/`cnt` registers and output registers. Target size is about 150–250 lines.

## Test plan
Each scenario uses a real `uart_tx` and samples the serial line every 33 cycles.

1. Req0 sends 0x41, 0x42, 0x43 with `last` on 0x43. Required: three `tx_valid_out` single-cycle pulses, serial bytes decode in that order, `grant_out`=0001 throughout, and IDLE with `ptr`=1 at the end.
2. After reset, all four requesters assert single-byte last packets 0xA0..0xA3 in the same cycle. Required: grants go 0, 1, 2, 3 and the wire carries A0, A1, A2, A3.
3. Req0 is continuously valid with 1-byte packets while req2 raises a single packet mid-stream. Required: req2 is served right after the current req0 packet, then req0 resumes.
4. With `MAX_BURST`=16, req1 sends 20 bytes 0x00..0x13 (last on 0x13) while req3 waits with 0x77. Required: wire order is 0x00..0x0F, 0x77, 0x10..0x13.
5. Req2 drops `req_valid_in` for 500 cycles mid-packet while req0 is valid. Required: `grant_out` stays 0100, req0 is not served until req2's last byte, and no stray `tx_valid_out` pulses occur.
6. Assert `rst_in` during WAIT_DONE. Required: on the next cycle every output reads 0 and `busy_out`=0, and a subsequent req3 request is granted normally (`ptr`=0 scan).
